// File: rtl/mux_scan_pkg.sv
// Shared constants and types for the mux scan sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux_scan_pkg;

  // Select codes covered by one scan; code 3'b111 is never produced.
  localparam logic [2:0] SEL_FIRST = 3'd0;
  localparam logic [2:0] SEL_LAST  = 3'd6;

  // Sequencer states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  // Next select code within a scan. Callers only use this below SEL_LAST.
  function automatic logic [2:0] next_sel(input logic [2:0] sel);
    return sel + 3'd1;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Down-counter that paces select steps; tick is high while count is zero.
// Latency: tick rises TICK_DIV-1 cycles after load (same cycle for TICK_DIV=1).
// Backpressure: none; load always wins and restarts the interval.
module rate_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic load,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Reload on request, otherwise count down and rest at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = RELOAD;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the 7:1 mux select 0..6, samples MuxOut per step, publishes a 7-bit word.
// Latency: 7*TICK_DIV cycles from Start accept to Done/Captured visible.
// Backpressure: Start ignored while Busy; Continuous chains scans with no gap.
module mux_scan_sequencer #(
  parameter int TICK_DIV = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Continuous,
  input  logic       MuxOut,
  output logic [2:0] MuxSelect,
  output logic       Busy,
  output logic       Done,
  output logic [6:0] Captured
);

  import mux_scan_pkg::*;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [5:0] shadow_q, shadow_d;
  logic [6:0] captured_q, captured_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       load;
  logic       tick;

  rate_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_rate_divider (
    .Clock(Clock),
    .Reset(Reset),
    .load (load),
    .tick (tick)
  );

  // Scan control: accept Start when idle, sample on each tick, wrap or stop at code 6.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    captured_d = captured_q;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d = SEL_FIRST;
        if (Start) begin
          state_d = STEP;
          load    = 1'b1;
        end
      end
      STEP: begin
        if (tick) begin
          if (sel_q != SEL_LAST) begin
            shadow_d[sel_q] = MuxOut;
            sel_d           = next_sel(sel_q);
            load            = 1'b1;
          end else begin
            // Final sample goes straight into the published word.
            captured_d = {MuxOut, shadow_q};
            done_d     = 1'b1;
            sel_d      = SEL_FIRST;
            if (Continuous) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_FIRST;
      end
    endcase
    busy_d = (state_d == STEP);
  end

  // State registers; reset aborts any scan in flight and drops its partial shadow.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      sel_q      <= SEL_FIRST;
      shadow_q   <= '0;
      captured_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      shadow_q   <= shadow_d;
      captured_q <= captured_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign MuxSelect = sel_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Captured  = captured_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: two instances (TICK_DIV=4 and TICK_DIV=1) each behind a 7:1 mux model.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: not applicable.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: TICK_DIV = 4
  logic       rst4, st4, cont4;
  logic [6:0] sw4;
  logic       mo4;
  logic [2:0] sel4;
  logic       busy4, done4;
  logic [6:0] cap4;

  // Instance B: TICK_DIV = 1
  logic       rst1, st1, cont1;
  logic [6:0] sw1;
  logic       mo1;
  logic [2:0] sel1;
  logic       busy1, done1;
  logic [6:0] cap1;

  // Downstream mux models: code 7 reads as 0.
  assign mo4 = (sel4 == 3'd7) ? 1'b0 : sw4[sel4];
  assign mo1 = (sel1 == 3'd7) ? 1'b0 : sw1[sel1];

  mux_scan_sequencer #(.TICK_DIV(4)) dut4 (
    .Clock(clk), .Reset(rst4), .Start(st4), .Continuous(cont4), .MuxOut(mo4),
    .MuxSelect(sel4), .Busy(busy4), .Done(done4), .Captured(cap4)
  );

  mux_scan_sequencer #(.TICK_DIV(1)) dut1 (
    .Clock(clk), .Reset(rst1), .Start(st1), .Continuous(cont1), .MuxOut(mo1),
    .MuxSelect(sel1), .Busy(busy1), .Done(done1), .Captured(cap1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One non-continuous scan on instance A. Optionally re-asserts Start mid-scan.
  task automatic scan4(input string tag, input logic [6:0] pat, input logic poke);
    int ndone;
    ndone = 0;
    sw4 = pat;
    st4 = 1'b1;
    @(negedge clk);            // accept edge E0 has passed
    st4 = 1'b0;
    for (int j = 0; j < 28; j++) begin
      chk({tag, "_sel"}, {29'd0, sel4}, j / 4);
      chk({tag, "_busy"}, {31'd0, busy4}, 32'd1);
      if (done4) ndone++;
      st4 = poke && (j == 5 || j == 10);
      @(negedge clk);
    end
    st4 = 1'b0;
    chk({tag, "_done"}, {31'd0, done4}, 32'd1);
    chk({tag, "_early_done"}, ndone, 32'd0);
    chk({tag, "_cap"}, {25'd0, cap4}, {25'd0, pat});
    chk({tag, "_idle_busy"}, {31'd0, busy4}, 32'd0);
    chk({tag, "_idle_sel"}, {29'd0, sel4}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done4}, 32'd0);
    chk({tag, "_cap_hold"}, {25'd0, cap4}, {25'd0, pat});
  endtask

  initial begin
    int waited;
    rst4 = 1'b1; st4 = 1'b0; cont4 = 1'b0; sw4 = 7'd0;
    rst1 = 1'b1; st1 = 1'b0; cont1 = 1'b0; sw1 = 7'd0;
    @(negedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    rst1 = 1'b0;

    // Reset then idle for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      chk("idle4", {18'd0, sel4, busy4, done4, cap4}, 32'd0);
      chk("idle1", {18'd0, sel1, busy1, done1, cap1}, 32'd0);
      @(negedge clk);
    end

    // Single scan, TICK_DIV=4.
    scan4("single", 7'b1010011, 1'b0);

    // Start pokes during Busy are ignored.
    scan4("poke", 7'b0101100, 1'b1);

    // Reset mid-scan after a prior 0x55 capture.
    scan4("pre55", 7'h55, 1'b0);
    sw4 = 7'b0110101;
    st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    for (int j = 0; j < 12; j++) @(negedge clk);
    chk("rst_at_sel3", {29'd0, sel4}, 32'd3);
    chk("rst_prior_cap", {25'd0, cap4}, 32'h55);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    chk("rst_abort", {18'd0, sel4, busy4, done4, cap4}, 32'd0);
    for (int i = 0; i < 30; i++) begin
      chk("rst_no_done", {31'd0, done4}, 32'd0);
      @(negedge clk);
    end
    scan4("fresh", 7'b0110101, 1'b0);

    // Continuous, TICK_DIV=1: 10 back-to-back scans.
    sw1 = 7'b0000001;
    cont1 = 1'b1;
    st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    for (int j = 0; j < 70; j++) begin
      chk("cont_sel", {29'd0, sel1}, j % 7);
      chk("cont_not7", {31'd0, (sel1 == 3'd7)}, 32'd0);
      chk("cont_done", {31'd0, done1}, {31'd0, (j > 0 && j % 7 == 0)});
      chk("cont_busy", {31'd0, busy1}, 32'd1);
      if (j == 7)  chk("cont_cap1", {25'd0, cap1}, 32'b0000001);
      if (j == 14) chk("cont_cap2", {25'd0, cap1}, 32'b1111001);
      if (j == 10) sw1 = 7'b1111110;
      @(negedge clk);
    end
    cont1 = 1'b0;
    waited = 0;
    while (busy1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("cont_stop", {31'd0, busy1}, 32'd0);
    chk("cont_final_cap", {25'd0, cap1}, 32'b1111110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Sequential scanner that sits directly upstream of the 7-to-1 switch multiplexer. It drives the multiplexer's 3-bit select through codes 0..6 at a programmable rate and samples the multiplexer's single-bit output after each step. It then presents the seven sampled bits as one parallel word with a done pulse. Used to self-test the mux and to read all seven data switches through the single mux output.

## Interface

Parameters:
- TICK_DIV, default 4: clock cycles per select step (settle + sample); legal range 1..2^26.

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high; one clock and one reset, sampled on the rising edge of Clock.
- Start  in  1  level; a scan begins on any rising edge where Start=1 and the block is idle.
- Continuous  in  1  when 1 at the final sample of a scan, the next scan starts immediately.
- MuxOut  in  1  output of the downstream 7-to-1 multiplexer (its LEDR[0]).
- MuxSelect  out  3  select code driven to the multiplexer (its SW[9:7]).
- Busy  out  1  high while a scan is in progress.
- Done  out  1  one-cycle pulse when Captured is updated.
- Captured  out  7  last completed scan; bit k = MuxOut sampled while MuxSelect=k.

## Operation

- States: IDLE, STEP. No other states.
- Reset values:
  - MuxSelect=0, Busy=0, Done=0, Captured=7'b0.
  - Divider count=0, shadow=0, state IDLE.
- IDLE:
  - MuxSelect held at 0.
  - On an edge with Start=1: state becomes STEP, sel=0, count=TICK_DIV-1, Busy=1.
- STEP, count≠0: count decrements; MuxSelect stays at sel.
- STEP, count=0 (sample edge): shadow[sel] ← MuxOut.
  - sel<6: sel increments, count reloads to TICK_DIV-1.
  - sel=6:
    - Captured ← {MuxOut, shadow[5:0]}.
    - Done=1 for exactly the following cycle.
    - If Continuous=1: stay in STEP with sel=0, count=TICK_DIV-1, Busy stays 1.
    - Else: state becomes IDLE, Busy=0, MuxSelect=0.
- MuxSelect is never driven to 3'b111.
- Start while Busy=1 is ignored; it is not queued.
- Captured changes only on the final sample edge or on Reset. It holds across IDLE.
- Reset mid-scan aborts immediately:
  - All outputs return to reset values.
  - Partial shadow is discarded and no Done is issued.
- Count width is $clog2(TICK_DIV), minimum 1 bit. With TICK_DIV=1, count stays 0 and every STEP cycle is a sample edge.

## Timing

- Start-accept edge E0: Busy and MuxSelect=0 are visible in the cycle after E0.
- Sample for select k occurs at edge E0+(k+1)·TICK_DIV. MuxOut must be stable for the TICK_DIV-1 cycles before that edge.
- Final sample is at E0+7·TICK_DIV. Done and the new Captured are visible in the cycle after it.
- Scan latency is 7·TICK_DIV cycles.
- In Continuous mode, back-to-back scans have no gap. Done pulses every 7·TICK_DIV cycles.
- In non-continuous mode, the earliest next Start accept is the edge after Done becomes visible. Start held high yields a one-cycle idle gap between scans.
- MuxOut is treated as synchronous to Clock; no synchronizer.

## Structure

- Shared package mux_scan_pkg:
  - SEL_FIRST=3'd0, SEL_LAST=3'd6.
  - State enum {IDLE, STEP}.
- One sub-module, rate_divider:
  - Parameter TICK_DIV.
  - Inputs Clock, Reset, load.
  - Output tick, high when count=0.
  - The sequencer instantiates it and uses tick as the sample strobe.
- Mux is not instantiated inside. The top-level test wrapper connects MuxSelect→SW[9:7], SW[6:0] pattern, LEDR[0]→MuxOut.

## Test plan

- Reset then idle:
  - Stimulus: Reset high 2 cycles, Start=0 for 20 cycles.
  - Required: MuxSelect=0, Busy=0, Done=0, Captured=0 throughout.
- Single scan, TICK_DIV=4, mux data SW[6:0]=7'b1010011:
  - Stimulus: Start pulse 1 cycle.
  - Required: MuxSelect steps 0..6, 4 cycles each.
  - Required: Done exactly once, 28 cycles after accept; Captured=7'b1010011; Busy low afterwards.
- Continuous, TICK_DIV=1:
  - Stimulus: pattern 7'b0000001, changed to 7'b1111110 during the second scan only after its sample edges for k≥3.
  - Required: Done every 7 cycles, no gap.
  - Required: first Captured=7'b0000001; second Captured mixes per-k sample times (bits 6..3=1, 2..0 per old pattern).
- Start during Busy:
  - Stimulus: Start re-asserted at cycles 5 and 10 of a TICK_DIV=4 scan.
  - Required: no restart, one Done at cycle 28, MuxSelect sequence unchanged.
- Reset mid-scan:
  - Stimulus: Reset at MuxSelect=3 after a prior Captured=7'h55.
  - Required: next cycle MuxSelect=0, Busy=0, Captured=0, no Done; a fresh Start then completes normally.
- Select bound:
  - Stimulus: 10 continuous scans.
  - Required: MuxSelect never equals 7.
